// File: rtl/servant_pkg.sv
// Shared definitions for the servant RAM loader.
//   state_t  : loader FSM states
//   lanemask : expands a 4-bit Wishbone byte-select into a 32-bit bit mask
package servant_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        GAP,
        WRITE,
        READ,
        DONE
    } state_t;

    function automatic logic [31:0] lanemask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/servant_wb_loader_if.sv
// Wishbone bus between the loader (master) and the RAM port / arbiter (slave).
//   adr : word address [aw-1:2]
//   dat : write data
//   sel : byte lanes
//   we  : write enable
//   cyc : cycle/strobe
//   rdt : read data, valid while ack is high
//   ack : single-cycle acknowledge
interface servant_wb_loader_if #(
    parameter int aw = 8
);
    logic [aw-1:2] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic [31:0]   rdt;
    logic          ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_wb_packer.sv
// Byte-to-word packer for the RAM loader.
// Accepted bytes land little-endian in lane[cnt] with the matching select bit
// set; the word and its select stay stable until i_clear.
//   i_wb_clk, i_wb_rst_n : clock, asynchronous active-low reset
//   i_clear              : empty the word (cnt, lanes, sel, last flag)
//   i_accept             : a byte is taken this cycle
//   i_data, i_last       : byte and end-of-stream marker
//   o_word_valid         : the byte taken now completes the word (4th or last)
//   o_dat, o_sel, o_last : assembled word, lane selects, word holds last byte
module servant_wb_packer (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic        o_word_valid,
    output logic [31:0] o_dat,
    output logic [3:0]  o_sel,
    output logic        o_last
);

    logic [1:0] cnt;

    // Combinational so the FSM can leave FILL on the same edge the byte lands.
    assign o_word_valid = i_accept && (cnt == 2'd3 || i_last);

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            cnt    <= 2'd0;
            o_dat  <= 32'd0;
            o_sel  <= 4'd0;
            o_last <= 1'b0;
        end else if (i_clear) begin
            cnt    <= 2'd0;
            o_dat  <= 32'd0;
            o_sel  <= 4'd0;
            o_last <= 1'b0;
        end else if (i_accept) begin
            o_dat[{cnt, 3'b000} +: 8] <= i_data;
            o_sel[cnt]                <= 1'b1;
            o_last                    <= i_last;
            cnt                       <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/servant_wb_loader.sv
// Wishbone initiator that fills the servant RAM from a byte stream.
// Bytes are packed little-endian into words, each word is written at
// consecutive addresses starting at BASE, and optionally read back and
// compared. A cyc-low cycle always separates consecutive bus cycles.
//   i_wb_clk, i_wb_rst_n : clock, asynchronous active-low reset
//   i_start              : begin a load from BASE (ignored while busy)
//   i_valid/i_data/i_last, o_ready : byte stream handshake
//   o_busy               : any state other than IDLE and DONE
//   o_done               : load finished, held until the next i_start
//   o_err                : sticky verify-mismatch / ack-timeout flag
//   wb                   : Wishbone master port
module servant_wb_loader
    import servant_pkg::*;
#(
    parameter int depth   = 256,
    parameter int aw      = $clog2(depth),
    parameter int BASE    = 0,
    parameter int VERIFY  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst_n,
    input  logic       i_start,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    servant_wb_loader_if.master wb
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [aw-1:0] BASE_B   = aw'(BASE);
    localparam logic [aw-1:2] BASE_W   = BASE_B[aw-1:2];

    state_t          state;
    logic [aw-1:2]   adr;
    logic            cyc;
    logic            we;
    logic            rd_phase;
    logic [TW-1:0]   tmo;

    logic            pk_accept;
    logic            pk_clear;
    logic            pk_word_valid;
    logic [31:0]     pk_dat;
    logic [3:0]      pk_sel;
    logic            pk_last;

    logic            start_ok;
    logic            word_fin;
    logic            mismatch;

    always_comb begin
        start_ok  = i_start && (state == IDLE || state == DONE);
        // Last bus cycle of a word: the write when not verifying, else the read.
        word_fin  = wb.ack && ((state == WRITE && VERIFY == 0) || state == READ);
        // Empty the packer on exactly the edges that move the FSM into FILL.
        pk_clear  = start_ok || (word_fin && !pk_last);
        pk_accept = i_valid && o_ready;
        mismatch  = (wb.rdt & lanemask(pk_sel)) != (pk_dat & lanemask(pk_sel));
    end

    servant_wb_packer u_packer (
        .i_wb_clk     (i_wb_clk),
        .i_wb_rst_n   (i_wb_rst_n),
        .i_clear      (pk_clear),
        .i_accept     (pk_accept),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_word_valid (pk_word_valid),
        .o_dat        (pk_dat),
        .o_sel        (pk_sel),
        .o_last       (pk_last)
    );

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state    <= IDLE;
            adr      <= '0;
            cyc      <= 1'b0;
            we       <= 1'b0;
            rd_phase <= 1'b0;
            tmo      <= '0;
            o_ready  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state   <= FILL;
                        adr     <= BASE_W;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                        o_done  <= 1'b0;
                        o_err   <= 1'b0;
                    end
                end
                FILL: begin
                    if (pk_word_valid) begin
                        state    <= GAP;
                        o_ready  <= 1'b0;
                        rd_phase <= 1'b0;
                    end
                end
                GAP: begin
                    // Timeout counter restarts with every cyc rise.
                    state <= rd_phase ? READ : WRITE;
                    cyc   <= 1'b1;
                    we    <= !rd_phase;
                    tmo   <= '0;
                end
                WRITE, READ: begin
                    if (wb.ack) begin
                        cyc <= 1'b0;
                        we  <= 1'b0;
                        if (state == READ && mismatch) begin
                            o_err <= 1'b1;
                        end
                        if (state == WRITE && VERIFY != 0) begin
                            state    <= GAP;
                            rd_phase <= 1'b1;
                        end else if (pk_last) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state   <= FILL;
                            adr     <= adr + 1'b1;
                            o_ready <= 1'b1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Abandon the load; the rest of the stream stays with the source.
                        cyc    <= 1'b0;
                        we     <= 1'b0;
                        o_err  <= 1'b1;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.adr = adr;
    assign wb.cyc = cyc;
    assign wb.we  = we;
    assign wb.sel = pk_sel;
    assign wb.dat = pk_dat;

endmodule

// File: tb/tb_servant_wb_loader.sv
// Directed bench for servant_wb_loader.
// u0: BASE=0,   VERIFY=0 - basic load, partial and single-byte words, ack timeout.
// u1: BASE=252, VERIFY=1 - address wrap, verify pass/fail, restart, async reset.
module tb_servant_wb_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, valid0, last0, ready0, busy0, done0, err0;
    logic       start1, valid1, last1, ready1, busy1, done1, err1;
    logic [7:0] data0, data1;

    servant_wb_loader_if #(.aw(8)) bus0 ();
    servant_wb_loader_if #(.aw(8)) bus1 ();

    servant_wb_loader #(.depth(256), .BASE(0), .VERIFY(0), .TIMEOUT(15)) u0 (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_start(start0), .i_valid(valid0),
        .i_data(data0), .i_last(last0), .o_ready(ready0), .o_busy(busy0),
        .o_done(done0), .o_err(err0), .wb(bus0)
    );

    servant_wb_loader #(.depth(256), .BASE(252), .VERIFY(1), .TIMEOUT(15)) u1 (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_start(start1), .i_valid(valid1),
        .i_data(data1), .i_last(last1), .o_ready(ready1), .o_busy(busy1),
        .o_done(done1), .o_err(err1), .wb(bus1)
    );

    // RAM models: ack one cycle after cyc rises, write/read on that same edge.
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic        ack_en0  = 1'b1;
    int          corrupt1 = -1;
    int          wr0 = 0, rd0 = 0, cyc_cnt0 = 0;
    int          wr1 = 0, rd1 = 0, rise1 = 0;
    logic [3:0]  wsel0 = 4'd0;
    logic        cyc1_d = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        bus0.ack <= bus0.cyc && !bus0.ack && ack_en0;
        if (bus0.cyc) cyc_cnt0 <= cyc_cnt0 + 1;
        if (bus0.cyc && !bus0.ack && ack_en0) begin
            if (bus0.we) begin
                mem0[bus0.adr] <= merge(mem0[bus0.adr], bus0.dat, bus0.sel);
                wsel0          <= bus0.sel;
                wr0            <= wr0 + 1;
            end else begin
                bus0.rdt <= mem0[bus0.adr];
                rd0      <= rd0 + 1;
            end
        end
    end

    always @(posedge clk) begin
        bus1.ack <= bus1.cyc && !bus1.ack;
        cyc1_d   <= bus1.cyc;
        if (bus1.cyc && !cyc1_d) rise1 <= rise1 + 1;
        if (bus1.cyc && !bus1.ack) begin
            if (bus1.we) begin
                mem1[bus1.adr] <= merge(mem1[bus1.adr], bus1.dat, bus1.sel);
                wr1            <= wr1 + 1;
            end else begin
                bus1.rdt <= mem1[bus1.adr] ^ ((int'(bus1.adr) == corrupt1) ? 32'h1 : 32'h0);
                rd1      <= rd1 + 1;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? ready0 : ready1;
    endfunction

    function automatic logic dn(input int k);
        return (k == 0) ? done0 : done1;
    endfunction

    task automatic pulse_start(input int k);
        @(negedge clk);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        int t;
        @(negedge clk);
        if (k == 0) begin valid0 = 1'b1; data0 = d; last0 = l; end
        else        begin valid1 = 1'b1; data1 = d; last1 = l; end
        t = 0;
        while (!rdy(k) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", 32'(rdy(k)), 32'd1);
        @(posedge clk);
        #1;
        valid0 = 1'b0; valid1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int t;
        t = 0;
        while (!dn(k) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wait_done", 32'(dn(k)), 32'd1);
    endtask

    localparam logic [7:0] S1 [8] = '{8'h13, 8'h04, 8'h40, 8'h00, 8'h73, 8'h10, 8'h04, 8'h7b};

    initial begin
        int c;
        int t;
        rst_n  = 1'b0;
        start0 = 1'b0; valid0 = 1'b0; last0 = 1'b0; data0 = 8'd0;
        start1 = 1'b0; valid1 = 1'b0; last1 = 1'b0; data1 = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cyc",   32'(bus0.cyc), 32'd0);
        chk("rst_we",    32'(bus0.we),  32'd0);
        chk("rst_sel",   32'(bus0.sel), 32'd0);
        chk("rst_dat",   bus0.dat,      32'd0);
        chk("rst_adr",   32'(bus0.adr), 32'd0);
        chk("rst_ready", 32'(ready0),   32'd0);
        chk("rst_done",  32'(done0),    32'd0);
        chk("rst_err",   32'(err0),     32'd0);
        chk("rst_busy",  32'(busy1),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(ready0), 32'd0);

        // Basic load, two full words
        pulse_start(0);
        chk("t1_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 8; i++) push(0, S1[i], i == 7);
        wait_done(0);
        chk("t1_mem0",  mem0[0],        32'h00400413);
        chk("t1_mem1",  mem0[1],        32'h7b041073);
        chk("t1_sel",   32'(wsel0),     32'h0000000f);
        chk("t1_wr",    32'(wr0),       32'd2);
        chk("t1_rd",    32'(rd0),       32'd0);
        chk("t1_err",   32'(err0),      32'd0);
        chk("t1_busy",  32'(busy0),     32'd0);
        chk("t1_ready", 32'(ready0),    32'd0);
        chk("t1_cyc",   32'(bus0.cyc),  32'd0);

        // Restart from DONE: full word then a 3-byte partial word
        pulse_start(0);
        chk("t2_done_clr", 32'(done0), 32'd0);
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b0); push(0, 8'h44, 1'b0);
        push(0, 8'haa, 1'b0); push(0, 8'hbb, 1'b0); push(0, 8'hcc, 1'b1);
        wait_done(0);
        chk("t2_mem0", mem0[0],    32'h44332211);
        chk("t2_mem1", mem0[1],    32'h7bccbbaa);
        chk("t2_sel",  32'(wsel0), 32'h00000007);
        chk("t2_wr",   32'(wr0),   32'd4);

        // Single-byte word (last on byte 0)
        pulse_start(0);
        push(0, 8'h5a, 1'b1);
        wait_done(0);
        chk("t2b_mem0", mem0[0],    32'h4433225a);
        chk("t2b_sel",  32'(wsel0), 32'h00000001);
        chk("t2b_wr",   32'(wr0),   32'd5);

        // Ack timeout
        ack_en0 = 1'b0;
        c = cyc_cnt0;
        pulse_start(0);
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b0);
        wait_done(0);
        chk("t3_cyc_len", 32'(cyc_cnt0 - c), 32'd15);
        chk("t3_err",     32'(err0),         32'd1);
        chk("t3_ready",   32'(ready0),       32'd0);
        chk("t3_busy",    32'(busy0),        32'd0);
        chk("t3_cyc",     32'(bus0.cyc),     32'd0);
        chk("t3_wr",      32'(wr0),          32'd5);
        ack_en0 = 1'b1;

        // Verify pass with address wrap 63 -> 0
        pulse_start(1);
        chk("t4_adr", 32'(bus1.adr), 32'd63);
        for (int i = 0; i < 8; i++) push(1, S1[i], i == 7);
        wait_done(1);
        chk("t4_mem63", mem1[63],    32'h00400413);
        chk("t4_mem0",  mem1[0],     32'h7b041073);
        chk("t4_rise",  32'(rise1),  32'd4);
        chk("t4_wr",    32'(wr1),    32'd2);
        chk("t4_rd",    32'(rd1),    32'd2);
        chk("t4_err",   32'(err1),   32'd0);

        // Verify fail on the second word (word 0 read corrupted)
        corrupt1 = 0;
        pulse_start(1);
        for (int i = 0; i < 8; i++) push(1, 8'(i + 1), i == 7);
        wait_done(1);
        chk("t5_err",   32'(err1), 32'd1);
        chk("t5_mem63", mem1[63],  32'h04030201);
        chk("t5_mem0",  mem1[0],   32'h08070605);
        chk("t5_rd",    32'(rd1),  32'd4);

        // Restart clears err, then async reset in the middle of a write
        corrupt1 = -1;
        pulse_start(1);
        chk("t6_err_clr",  32'(err1),     32'd0);
        chk("t6_done_clr", 32'(done1),    32'd0);
        chk("t6_adr",      32'(bus1.adr), 32'd63);
        push(1, 8'h09, 1'b0); push(1, 8'h08, 1'b0); push(1, 8'h07, 1'b0); push(1, 8'h06, 1'b0);
        t = 0;
        while (!(bus1.cyc && bus1.we) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t6_in_write", 32'(bus1.cyc && bus1.we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc",   32'(bus1.cyc), 32'd0);
        chk("t6_rst_busy",  32'(busy1),    32'd0);
        chk("t6_rst_ready", 32'(ready1),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_ready", 32'(ready1),   32'd0);
        chk("t6_idle_cyc",   32'(bus1.cyc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/servant_wb_loader.md
Name: servant_wb_loader

Overview:
- Wishbone initiator that fills the servant RAM from a byte stream (UART/debug-link loader) before or between CPU runs.
- Packs incoming bytes little-endian into 32-bit words and issues one write cycle per word at consecutive addresses.
- Can optionally read back each word and compare it.
- Sits between the host byte source and the RAM's Wishbone port, behind the same arbiter the CPU uses.

Parameters:
- depth, 256, RAM size in bytes; address wraps modulo depth.
- aw, $clog2(depth), byte address width.
- BASE, 0, byte address of the first word; word aligned, bits [1:0] ignored.
- VERIFY, 1, 1 = read back each written word and compare it.
- TIMEOUT, 15, maximum cycles to wait for i_wb_ack; counter width $clog2(TIMEOUT+1).

Ports:
- i_wb_clk  in  1  clock.
- i_wb_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; begins a load from BASE and clears o_err and o_done.
- i_valid  in  1  byte stream valid.
- i_data  in  8  byte stream data.
- i_last  in  1  marks the final byte; qualified by i_valid.
- o_ready  out  1  byte accepted when i_valid & o_ready.
- o_busy  out  1  high in any state except IDLE and DONE.
- o_done  out  1  load finished; held until i_start.
- o_err  out  1  sticky; set by verify mismatch or ack timeout.
- o_wb_adr  out  aw-2  word address [aw-1:2].
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  byte lanes.
- o_wb_we  out  1  write enable.
- o_wb_cyc  out  1  cycle/strobe.
- i_wb_rdt  in  32  read data, valid when i_wb_ack is high.
- i_wb_ack  in  1  single-cycle acknowledge.

Behaviour:
- Reset values: state IDLE; o_wb_cyc, o_wb_we, o_wb_sel, o_wb_dat, o_wb_adr, o_ready, o_done and o_err all 0; byte count 0.
- All outputs are registered.
- IDLE: o_ready=0; i_start -> FILL, address = BASE[aw-1:2].
- FILL: o_ready=1.
  - Each accepted byte goes to lane[cnt]; sel[cnt] is set; cnt increments.
  - Leave FILL when the 4th byte is accepted or a byte with i_last is accepted.
  - o_ready drops on the following cycle; no byte is accepted outside FILL.
  - Next state is GAP -> WRITE.
  - Unused lanes have sel=0 and data 0.
- WRITE: cyc=1, we=1, sel and data held stable until ack.
  - On ack: cyc=0 the next cycle.
  - Then: GAP -> READ if VERIFY; otherwise the "after word" step.
- READ: cyc=1, we=0, same address and sel.
  - On ack: compare (i_wb_rdt & lanemask(sel)) with (data & lanemask(sel)).
  - A mismatch sets o_err.
  - Then the "after word" step.
- After word:
  - If the word contained last -> DONE.
  - Otherwise address+1 modulo depth/4, cnt=0, sel=0 -> FILL.
- GAP: one cycle with cyc=0 between consecutive bus cycles. This is mandatory and makes the RAM's ack toggle cleanly.
- Timeout: the wait counter clears on cyc rise. If it reaches TIMEOUT without ack: o_err=1, cyc=0, -> DONE. Any remaining stream is not consumed.
- DONE: o_done=1; i_start -> FILL (address=BASE, err/done cleared, cnt=0).
- i_start while busy is ignored.
- i_last on byte 0 of a word gives sel=0001 and a single-byte write.
- i_valid with i_last=0 after the 4th byte waits in the source until FILL re-enters (o_ready low).
- Address wrap: word depth/4-1 is followed by word 0; no error is raised.
- Async reset mid-cycle: cyc drops immediately and the state returns to IDLE; the RAM may have completed a partial write, which is acceptable.

Decomposition:
- Shared package servant_pkg:
  - state enum: IDLE, FILL, GAP, WRITE, READ, DONE.
  - lanemask function mapping sel[3:0] to a 32-bit mask.
- Sub-module servant_wb_packer: holds the byte counter, lane/sel assembly and the last flag. It exposes word_valid and a clear input.
- The top level keeps the FSM, address counter, timeout and verify logic.

Test Plan:
- Basic load: BASE=0, VERIFY=0, bytes 13 04 40 00 73 10 04 7b with last on the final byte -> writes mem[0]=00400413 and mem[1]=7b041073 with sel=1111; o_done=1; o_err=0.
- Verify pass: same stream with VERIFY=1 -> each word is written then read (4 bus cycles, cyc low between them); o_err=0.
- Partial word: bytes AA BB CC with last at BASE=8 -> one write at word 2 with sel=0111 and data 00CCBBAA; the RAM's top byte is unchanged.
- Verify fail: the RAM model corrupts bit 0 on read of word 1 -> o_err=1 at that ack; o_err stays 1; load continues to DONE.
- Timeout: ack tied low, TIMEOUT=15 -> cyc high exactly 15 cycles, then o_err=1, o_done=1, o_ready=0.
- Wrap and restart: BASE=252, depth=256, 8 bytes -> words 63 then 0 are written. i_start in DONE restarts at 63 with err cleared. Async reset during WRITE -> cyc=0 immediately and state IDLE.
